// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state and source encodings for the UART TX arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_CTRL = 1'b0,
    SRC_RECV = 1'b1
  } src_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer, UART and status signals of the TX arbiter
interface uart_tx_arbiter_if;

  logic [7:0] ctrl_data;
  logic       ctrl_write;
  logic [7:0] recv_data;
  logic       recv_write;
  logic       silence;
  logic       tx_busy;
  logic       drop_clr;
  logic [7:0] tx_in;
  logic       tx_write;
  logic       ctrl_drop;
  logic       recv_drop;
  logic       ctrl_empty;

  modport master (
    output ctrl_data, ctrl_write, recv_data, recv_write, silence, tx_busy, drop_clr,
    input  tx_in, tx_write, ctrl_drop, recv_drop, ctrl_empty
  );

  modport slave (
    input  ctrl_data, ctrl_write, recv_data, recv_write, silence, tx_busy, drop_clr,
    output tx_in, tx_write, ctrl_drop, recv_drop, ctrl_empty
  );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small first-word-fall-through byte FIFO, one per producer
module byte_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - schedules ctrl and recv bytes onto one UART write port
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_AW      = 2,
  parameter int HOLD_CYCLES  = 8,
  parameter int GAP_CYCLES   = 10000,
  parameter int MAX_CTRL_RUN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_CTRL_RUN + 1);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CTRL_RUN);

  logic             ctrl_write_r;
  logic             recv_write_r;
  logic             ctrl_push;
  logic             recv_push;
  logic             ctrl_pop;
  logic             recv_pop;
  logic [7:0]       ctrl_dout;
  logic [7:0]       recv_dout;
  logic             ctrl_full;
  logic             ctrl_empty;
  logic             recv_full;
  logic             recv_empty;
  logic             pick;
  src_t             sel;
  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run;
  logic [7:0]       tx_in_q;
  logic             tx_write_q;
  logic             ctrl_drop_q;
  logic             recv_drop_q;

  assign ctrl_push = bus.ctrl_write & ~ctrl_write_r;
  assign recv_push = bus.recv_write & ~recv_write_r & ~bus.silence;

  // Recv only wins when ctrl has nothing, or ctrl has used up its run allowance.
  assign sel      = (!recv_empty && (ctrl_empty || (run == RUN_MAX))) ? SRC_RECV : SRC_CTRL;
  assign pick     = (state == ST_IDLE) && !bus.tx_busy && (!ctrl_empty || !recv_empty);
  assign ctrl_pop = pick && (sel == SRC_CTRL);
  assign recv_pop = pick && (sel == SRC_RECV);

  byte_fifo #(.AW(FIFO_AW)) u_ctrl_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ctrl_push),
    .din   (bus.ctrl_data),
    .pop   (ctrl_pop),
    .dout  (ctrl_dout),
    .full  (ctrl_full),
    .empty (ctrl_empty)
  );

  byte_fifo #(.AW(FIFO_AW)) u_recv_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (recv_push),
    .din   (bus.recv_data),
    .pop   (recv_pop),
    .dout  (recv_dout),
    .full  (recv_full),
    .empty (recv_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_write_r <= 1'b0;
      recv_write_r <= 1'b0;
      ctrl_drop_q  <= 1'b0;
      recv_drop_q  <= 1'b0;
    end else begin
      ctrl_write_r <= bus.ctrl_write;
      recv_write_r <= bus.recv_write;
      if (ctrl_push && ctrl_full && !ctrl_pop) begin
        ctrl_drop_q <= 1'b1;
      end else if (bus.drop_clr) begin
        ctrl_drop_q <= 1'b0;
      end
      if (recv_push && recv_full && !recv_pop) begin
        recv_drop_q <= 1'b1;
      end else if (bus.drop_clr) begin
        recv_drop_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      run        <= '0;
      tx_in_q    <= 8'h00;
      tx_write_q <= 1'b0;
    end else begin
      if (recv_empty) begin
        run <= '0;
      end else if (pick) begin
        run <= (sel == SRC_RECV) ? '0 : run + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pick) begin
            tx_in_q    <= (sel == SRC_RECV) ? recv_dout : ctrl_dout;
            tx_write_q <= 1'b1;
            cnt        <= CNT_W'(1);
            state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          cnt <= cnt + 1'b1;
          if (cnt == HOLD_C) begin
            tx_write_q <= 1'b0;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Saturate so a long tx_busy stretch cannot wrap the counter.
          if (cnt < GAP_C) begin
            cnt <= cnt + 1'b1;
          end
          if ((cnt >= GAP_C) && !bus.tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_in      = tx_in_q;
  assign bus.tx_write   = tx_write_q;
  assign bus.ctrl_drop  = ctrl_drop_q;
  assign bus.recv_drop  = recv_drop_q;
  assign bus.ctrl_empty = ctrl_empty;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int HOLD = 8;
  localparam int GAP  = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic prev_w      = 1'b0;
  logic [7:0] sent_q [$];
  int         rise_q [$];

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .FIFO_AW      (2),
    .HOLD_CYCLES  (HOLD),
    .GAP_CYCLES   (GAP),
    .MAX_CTRL_RUN (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_write && !prev_w) begin
      sent_q.push_back(bus.tx_in);
      rise_q.push_back(cyc);
    end
    prev_w = bus.tx_write;
  end

  task automatic pulse_ctrl(input logic [7:0] d);
    @(negedge clk);
    bus.ctrl_data  = d;
    bus.ctrl_write = 1'b1;
    @(negedge clk);
    bus.ctrl_write = 1'b0;
  endtask

  task automatic pulse_recv(input logic [7:0] d);
    @(negedge clk);
    bus.recv_data  = d;
    bus.recv_write = 1'b1;
    @(negedge clk);
    bus.recv_write = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.ctrl_data = 8'h00; bus.ctrl_write = 1'b0;
    bus.recv_data = 8'h00; bus.recv_write = 1'b0;
    bus.silence = 1'b0; bus.tx_busy = 1'b0; bus.drop_clr = 1'b0;
    rst_n = 1'b0;
    settle(3);
    vectors++;
    if (bus.tx_write !== 1'b0 || bus.tx_in !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx got write=%b in=%h want write=0 in=00", bus.tx_write, bus.tx_in);
    end
    vectors++;
    if (bus.ctrl_drop !== 1'b0 || bus.recv_drop !== 1'b0 || bus.ctrl_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags got cd=%b rd=%b ce=%b want 0 0 1", bus.ctrl_drop, bus.recv_drop, bus.ctrl_empty);
    end
    rst_n = 1'b1;
    settle(3);
    vectors++;
    if (bus.tx_write !== 1'b0 || bus.ctrl_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got write=%b ce=%b want 0 1", bus.tx_write, bus.ctrl_empty);
    end
  endtask

  task automatic test_single_ctrl;
    int hc;
    sent_q.delete(); rise_q.delete();
    @(negedge clk);
    bus.ctrl_data  = 8'h01;
    bus.ctrl_write = 1'b1;
    @(negedge clk);
    bus.ctrl_write = 1'b0;
    vectors++;
    if (bus.tx_write !== 1'b0 || bus.ctrl_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL single_push_cycle got write=%b ce=%b want 0 0", bus.tx_write, bus.ctrl_empty);
    end
    @(negedge clk);
    vectors++;
    if (bus.tx_write !== 1'b1 || bus.tx_in !== 8'h01) begin
      miscompares++;
      $display("FAIL single_latency got write=%b in=%h want 1 01", bus.tx_write, bus.tx_in);
    end
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_write) hc++;
      @(negedge clk);
    end
    vectors++;
    if (hc != HOLD) begin
      miscompares++;
      $display("FAIL single_hold got %0d cycles want %0d", hc, HOLD);
    end
    settle(GAP);
  endtask

  task automatic test_simultaneous;
    sent_q.delete(); rise_q.delete();
    @(negedge clk);
    bus.ctrl_data = 8'h02; bus.ctrl_write = 1'b1;
    bus.recv_data = 8'hA5; bus.recv_write = 1'b1;
    @(negedge clk);
    bus.ctrl_write = 1'b0; bus.recv_write = 1'b0;
    for (int k = 0; k < 200 && sent_q.size() < 2; k++) @(negedge clk);
    vectors++;
    if (sent_q.size() < 2) begin
      miscompares++;
      $display("FAIL simul_timeout got %0d bytes want 2", sent_q.size());
    end else begin
      vectors++;
      if (sent_q[0] !== 8'h02 || sent_q[1] !== 8'hA5) begin
        miscompares++;
        $display("FAIL simul_order got %h %h want 02 a5", sent_q[0], sent_q[1]);
      end
      vectors++;
      if (rise_q[1] - rise_q[0] != GAP + 1) begin
        miscompares++;
        $display("FAIL simul_spacing got %0d want %0d", rise_q[1] - rise_q[0], GAP + 1);
      end
    end
    settle(GAP + 5);
  endtask

  task automatic test_recv_overflow;
    sent_q.delete(); rise_q.delete();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) pulse_recv(8'h10 + 8'(i));
    vectors++;
    if (bus.recv_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early_drop got %b want 0", bus.recv_drop);
    end
    for (int i = 4; i < 6; i++) pulse_recv(8'h10 + 8'(i));
    settle(1);
    vectors++;
    if (bus.recv_drop !== 1'b1 || sent_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_drop got drop=%b sent=%0d want 1 0", bus.recv_drop, sent_q.size());
    end
    bus.tx_busy = 1'b0;
    for (int k = 0; k < 300 && sent_q.size() < 4; k++) @(negedge clk);
    settle(GAP + 10);
    vectors++;
    if (sent_q.size() != 4) begin
      miscompares++;
      $display("FAIL ovf_count got %0d bytes want 4", sent_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (sent_q[i] !== 8'h10 + 8'(i)) begin
          miscompares++;
          $display("FAIL ovf_byte%0d got %h want %h", i, sent_q[i], 8'h10 + 8'(i));
        end
      end
    end
    @(negedge clk); bus.drop_clr = 1'b1;
    @(negedge clk); bus.drop_clr = 1'b0;
    vectors++;
    if (bus.recv_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear got %b want 0", bus.recv_drop);
    end
  endtask

  task automatic test_ctrl_run;
    logic [7:0] exp [9];
    exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h77, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    sent_q.delete(); rise_q.delete();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) pulse_ctrl(8'hC0 + 8'(i));
    pulse_recv(8'h77);
    bus.tx_busy = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 100 && sent_q.size() <= r; k++) @(negedge clk);
      pulse_ctrl(8'hC4 + 8'(r));
    end
    for (int k = 0; k < 600 && sent_q.size() < 9; k++) @(negedge clk);
    vectors++;
    if (sent_q.size() < 9) begin
      miscompares++;
      $display("FAIL run_timeout got %0d bytes want 9", sent_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (sent_q[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL run_byte%0d got %h want %h", i, sent_q[i], exp[i]);
        end
      end
    end
    settle(GAP + 5);
  endtask

  task automatic test_silence_drop;
    sent_q.delete(); rise_q.delete();
    bus.silence = 1'b1;
    pulse_recv(8'h33);
    bus.silence = 1'b0;
    settle(GAP);
    vectors++;
    if (sent_q.size() != 0 || bus.recv_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL silence got sent=%0d drop=%b want 0 0", sent_q.size(), bus.recv_drop);
    end
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) pulse_ctrl(8'hD0 + 8'(i));
    vectors++;
    if (bus.ctrl_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL ctrl_overflow got %b want 1", bus.ctrl_drop);
    end
    @(negedge clk); bus.drop_clr = 1'b1;
    @(negedge clk); bus.drop_clr = 1'b0;
    vectors++;
    if (bus.ctrl_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_clr got %b want 0", bus.ctrl_drop);
    end
    @(negedge clk);
    bus.ctrl_data = 8'hEE; bus.ctrl_write = 1'b1; bus.drop_clr = 1'b1;
    @(negedge clk);
    bus.ctrl_write = 1'b0; bus.drop_clr = 1'b0;
    vectors++;
    if (bus.ctrl_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins got %b want 1", bus.ctrl_drop);
    end
  endtask

  task automatic test_reset_mid;
    bus.tx_busy = 1'b0;
    for (int k = 0; k < 10 && !bus.tx_write; k++) @(negedge clk);
    vectors++;
    if (bus.tx_write !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_start got write=%b want 1", bus.tx_write);
    end
    settle(3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.tx_write !== 1'b0 || bus.ctrl_empty !== 1'b1 || bus.ctrl_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got write=%b ce=%b cd=%b want 0 1 0", bus.tx_write, bus.ctrl_empty, bus.ctrl_drop);
    end
    settle(2);
    rst_n = 1'b1;
    settle(2);
    sent_q.delete(); rise_q.delete();
    pulse_ctrl(8'h5A);
    for (int k = 0; k < 10 && sent_q.size() < 1; k++) @(negedge clk);
    settle(GAP + 5);
    vectors++;
    if (sent_q.size() != 1) begin
      miscompares++;
      $display("FAIL post_reset_count got %0d want 1", sent_q.size());
    end else begin
      vectors++;
      if (sent_q[0] !== 8'h5A) begin
        miscompares++;
        $display("FAIL post_reset_byte got %h want 5a", sent_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ctrl();
    test_simultaneous();
    test_recv_overflow();
    test_ctrl_run();
    test_silence_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
